// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM state encoding and request decode helpers
// shared by the load/store unit (optional feature macro: LSU_MISALIGNED_EN).
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        WR0,
        WR1,
        RESP
    } lsu_state_e;

    // Access size in bytes: 1, 2 or 4.
    function automatic logic [2:0] size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Stores only have the signed encodings; loads add BU/HU.
    function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
        if (wr) begin
            return f3 inside {F3_B, F3_H, F3_W};
        end
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane merge for read-modify-write stores and
// extract/extend for loads, over a two-word window {word1, word0}.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rbuf0_i,
    input  logic [31:0] rbuf1_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] st_word0_o,
    output logic [31:0] st_word1_o,
    output logic [31:0] ld_data_o
);

    logic [63:0] old_w;
    logic [63:0] mask;
    logic [63:0] ins;
    logic [63:0] merged;
    logic [31:0] shifted;
    logic [5:0]  sh;

    assign sh     = {offset_i, 3'b000};
    assign old_w  = {rbuf1_i, rbuf0_i};

    // Position size mask and store data at the byte offset, then merge.
    always_comb begin
        case (funct3_i[1:0])
            2'b00:   mask = 64'h0000_0000_0000_00FF;
            2'b01:   mask = 64'h0000_0000_0000_FFFF;
            default: mask = 64'h0000_0000_FFFF_FFFF;
        endcase
        mask    = mask << sh;
        ins     = {32'b0, wdata_i} << sh;
        merged  = (old_w & ~mask) | (ins & mask);
        shifted = 32'(old_w >> sh);
    end

    assign st_word0_o = merged[31:0];
    assign st_word1_o = merged[63:32];

    // Sign- or zero-extend the addressed bytes.
    always_comb begin
        unique case (funct3_i)
            F3_B:    ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ld_data_o = {24'b0, shifted[7:0]};
            F3_HU:   ld_data_o = {16'b0, shifted[15:0]};
            default: ld_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32 load/store FSM over a word memory without byte
// enables; LSU_MISALIGNED_EN enables split word-crossing accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDRSIZE = 5,
    parameter int WORDSIZE = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [2:0]          req_funct3,
    input  logic [31:0]         req_addr,
    input  logic [WORDSIZE-1:0] req_wdata,
    output logic                resp_valid,
    output logic [WORDSIZE-1:0] resp_rdata,
    output logic                resp_error,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [WORDSIZE-1:0] mem_wdata,
    input  logic [WORDSIZE-1:0] mem_rdata
);

    localparam int AW = ADDRSIZE + 2;

    lsu_state_e state_q, state_d;

    logic                write_q;
    logic [2:0]          f3_q;
    logic [AW-1:0]       addr_q;
    logic [WORDSIZE-1:0] wdata_q;
    logic [WORDSIZE-1:0] rbuf0_q;
    logic [WORDSIZE-1:0] rbuf1_q;
    logic [WORDSIZE-1:0] rdata_q;
    logic                err_q;
    logic                split_q;

    logic                accept;
    logic                req_err;
    logic                req_split;
    logic                req_sw_al;
    logic [2:0]          req_size;
    logic [ADDRSIZE-1:0] word0;
    logic [WORDSIZE-1:0] st0;
    logic [WORDSIZE-1:0] st1;
    logic [WORDSIZE-1:0] ld_data;
    logic [WORDSIZE-1:0] resp_now;
    logic                unused_addr;

    assign unused_addr = ^req_addr[31:AW];
    assign req_ready   = (state_q == IDLE);
    assign accept      = req_valid && req_ready;
    assign req_size    = size_bytes(req_funct3);
    assign req_sw_al   = req_write && (req_funct3 == F3_W)
                      && (req_addr[1:0] == 2'b00);
    assign word0       = addr_q[AW-1:2];

`ifdef LSU_MISALIGNED_EN
    logic [3:0]          req_end;
    logic [ADDRSIZE-1:0] word1;

    assign req_end   = {2'b00, req_addr[1:0]} + {1'b0, req_size};
    assign req_split = (req_end > 4'd4);
    assign req_err   = !f3_legal(req_write, req_funct3);
    assign word1     = word0 + ADDRSIZE'(1);
`else
    logic req_misal;
    logic unused_st1;

    assign req_misal  = (req_size == 3'd2) ? req_addr[0]
                      : (req_size == 3'd4) ? |req_addr[1:0]
                      : 1'b0;
    assign req_split  = 1'b0;
    assign req_err    = !f3_legal(req_write, req_funct3) || req_misal;
    assign unused_st1 = ^st1;
`endif

    lsu_align u_align (
        .rbuf0_i    (rbuf0_q),
        .rbuf1_i    (rbuf1_q),
        .offset_i   (addr_q[1:0]),
        .funct3_i   (f3_q),
        .wdata_i    (wdata_q),
        .st_word0_o (st0),
        .st_word1_o (st1),
        .ld_data_o  (ld_data)
    );

    // Next state and memory strobes; only read/write states touch memory.
    always_comb begin
        state_d   = state_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)        state_d = RESP;
                    else if (req_sw_al) state_d = WR0;
                    else                state_d = RD0;
                end
            end
            RD0: begin
                mem_read = 1'b1;
                mem_addr = word0;
                if (split_q)      state_d = RD1;
                else if (write_q) state_d = WR0;
                else              state_d = RESP;
            end
`ifdef LSU_MISALIGNED_EN
            RD1: begin
                mem_read = 1'b1;
                mem_addr = word1;
                state_d  = write_q ? WR0 : RESP;
            end
            WR1: begin
                mem_write = 1'b1;
                mem_addr  = word1;
                mem_wdata = st1;
                state_d   = RESP;
            end
`endif
            WR0: begin
                mem_write = 1'b1;
                mem_addr  = word0;
                mem_wdata = st0;
                state_d   = split_q ? WR1 : RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Capture the request and its decode at the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            split_q <= 1'b0;
        end else if (accept) begin
            write_q <= req_write;
            f3_q    <= req_funct3;
            addr_q  <= req_addr[AW-1:0];
            wdata_q <= req_wdata;
            err_q   <= req_err;
            split_q <= req_split;
        end
    end

    // Read buffers fill from the combinational memory read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbuf0_q <= '0;
            rbuf1_q <= '0;
        end else begin
            if (state_q == RD0) rbuf0_q <= mem_rdata;
            if (state_q == RD1) rbuf1_q <= mem_rdata;
        end
    end

    assign resp_now = (write_q || err_q) ? '0 : ld_data;

    // Hold the last response data until the next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                rdata_q <= '0;
        else if (state_q == RESP)  rdata_q <= resp_now;
    end

    assign resp_valid = (state_q == RESP);
    assign resp_error = resp_valid && err_q;
    assign resp_rdata = resp_valid ? resp_now : rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random requests checked against a
// byte-level memory model; LSU_MISALIGNED_EN selects split expectations.
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam int AS = 5;
    localparam int NW = 1 << AS;
`ifdef LSU_MISALIGNED_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_error;
    logic          mem_read;
    logic          mem_write;
    logic [AS-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic [31:0]   mem     [NW];
    logic [31:0]   ref_mem [NW];
    logic          poke_en;
    logic [AS-1:0] poke_idx;
    logic [31:0]   poke_val;

    int checks = 0;
    int errors = 0;

    // expectations, written by the driver at each accept
    int          req_id = 0;
    int          exp_lat;
    int          exp_writes;
    logic        exp_err;
    logic        exp_load;
    logic [31:0] exp_rdata;

    // observations, written by the compare process
    int          seen_id = 0;
    int          done_id = 0;
    bit          pending = 0;
    int          cyc;
    int          wcount;
    int          last_lat;
    int          last_writes;
    logic        last_err;
    logic [31:0] last_rdata;

    load_store_unit #(.ADDRSIZE(AS), .WORDSIZE(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (poke_en)        mem[poke_idx] <= poke_val;
        else if (mem_write) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rbyte(input int b);
        return ref_mem[b / 4][8 * (b % 4) +: 8];
    endfunction

    task automatic wbyte(input int b, input logic [7:0] v);
        ref_mem[b / 4][8 * (b % 4) +: 8] = v;
    endtask

    // Reference: byte-addressed memory, wrapping at 4*NW bytes.
    task automatic model(input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        int size, off, base;
        bit legal, misal, split;
        logic [31:0] v;
        legal = wr ? (f3 inside {3'd0, 3'd1, 3'd2})
                   : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off   = int'(addr[1:0]);
        base  = int'(addr[AS+1:0]);
        misal = (off % size) != 0;
        split = (off + size) > 4;
        exp_err    = !legal || (!FEAT && misal);
        exp_load   = !wr;
        exp_rdata  = '0;
        exp_writes = 0;
        if (exp_err) begin
            exp_lat = 1;
        end else if (!wr) begin
            v = '0;
            for (int i = 0; i < size; i++)
                v[8*i +: 8] = rbyte((base + i) % (4 * NW));
            if (size == 1 && !f3[2]) v = {{24{v[7]}}, v[7:0]};
            if (size == 2 && !f3[2]) v = {{16{v[15]}}, v[15:0]};
            exp_rdata = v;
            exp_lat   = split ? 3 : 2;
        end else begin
            for (int i = 0; i < size; i++)
                wbyte((base + i) % (4 * NW), wd[8*i +: 8]);
            exp_writes = split ? 2 : 1;
            exp_lat    = (size == 4 && off == 0) ? 2 : (split ? 5 : 3);
        end
    endtask

    task automatic poke(input logic [AS-1:0] idx, input logic [31:0] v);
        @(negedge clk);
        poke_en  = 1'b1;
        poke_idx = idx;
        poke_val = v;
        ref_mem[idx] = v;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic run_req(input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("ready_timeout", req_ready, 1);
        #1;
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        model(wr, f3, addr, wd);
        req_id++;
        // junk while busy: must be ignored
        req_valid  = 1'($urandom_range(0, 1));
        req_write  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        n = 0;
        while (done_id != req_id && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_id != req_id) check("resp_timeout", done_id, req_id);
        req_valid = 1'b0;
    endtask

    // Per-cycle compare of DUT outputs against the expectations.
    always @(negedge clk) begin
        int mism;
        if (rst_n === 1'b1) begin
            check("rd_wr_excl", {31'b0, mem_read && mem_write}, 0);
            if (req_id != seen_id) begin
                seen_id = req_id;
                pending = 1;
                cyc     = 0;
                wcount  = 0;
            end
            if (pending) begin
                cyc++;
                if (mem_write) wcount++;
                check("ready_busy", {31'b0, req_ready}, 0);
                if (exp_err)
                    check("err_no_mem", {31'b0, mem_read | mem_write}, 0);
                if (resp_valid) begin
                    check("latency", cyc, exp_lat);
                    check("resp_error", {31'b0, resp_error}, {31'b0, exp_err});
                    check("write_pulses", wcount, exp_writes);
                    if (exp_load && !exp_err)
                        check("resp_rdata", resp_rdata, exp_rdata);
                    mism = 0;
                    for (int i = 0; i < NW; i++)
                        if (mem[i] !== ref_mem[i]) mism++;
                    check("mem_image", mism, 0);
                    last_lat    = cyc;
                    last_writes = wcount;
                    last_err    = resp_error;
                    last_rdata  = resp_rdata;
                    pending     = 0;
                    done_id     = req_id;
                end
            end else begin
                check("resp_quiet", {31'b0, resp_valid}, 0);
            end
        end
    end

    initial begin
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        int          mism;

        rst_n      = 1'b0;
        poke_en    = 1'b0;
        poke_idx   = '0;
        poke_val   = '0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;

        #3;
        check("rst_ready", {31'b0, req_ready}, 1);
        check("rst_resp_valid", {31'b0, resp_valid}, 0);
        check("rst_resp_error", {31'b0, resp_error}, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_mem_read", {31'b0, mem_read}, 0);
        check("rst_mem_write", {31'b0, mem_write}, 0);
        check("rst_mem_addr", {27'b0, mem_addr}, 0);
        check("rst_mem_wdata", mem_wdata, 0);

        for (int i = 0; i < NW; i++) poke(AS'(i), $urandom);
        @(negedge clk);
        rst_n = 1'b1;

        // byte loads, sign and zero extension
        poke(5'd3, 32'h8899AABB);
        run_req(1'b0, 3'b000, 32'h0000_000D, 32'h0);
        check("lb_lit", last_rdata, 32'hFFFFFFAA);
        check("lb_lat", last_lat, 2);
        run_req(1'b0, 3'b100, 32'h0000_000D, 32'h0);
        check("lbu_lit", last_rdata, 32'h000000AA);

        // byte store via read-modify-write
        run_req(1'b1, 3'b000, 32'h0000_000E, 32'h0000_0012);
        check("sb_mem", mem[3], 32'h8812AABB);
        check("sb_lat", last_lat, 3);
        check("sb_writes", last_writes, 1);

        // aligned word store goes straight to memory
        run_req(1'b1, 3'b010, 32'h0000_0020, 32'hCAFEF00D);
        check("sw_mem", mem[8], 32'hCAFEF00D);
        check("sw_lat", last_lat, 2);

        poke(5'd4, 32'h44332211);
        poke(5'd5, 32'h88776655);
        poke(5'd31, 32'hA1A2A3A4);
        poke(5'd0, 32'hB1B2B3B4);
`ifdef LSU_MISALIGNED_EN
        run_req(1'b0, 3'b010, 32'h0000_0013, 32'h0);
        check("lw_split_lit", last_rdata, 32'h77665544);
        check("lw_split_lat", last_lat, 3);
        run_req(1'b1, 3'b010, 32'h0000_0013, 32'hDEADBEEF);
        check("sw_split_w4", mem[4], 32'hEF332211);
        check("sw_split_w5", mem[5], 32'h88DEADBE);
        check("sw_split_lat", last_lat, 5);
        check("sw_split_writes", last_writes, 2);
        run_req(1'b0, 3'b010, 32'h0000_007E, 32'h0);
        check("lw_wrap_lit", last_rdata, 32'hB3B4A1A2);
`else
        run_req(1'b0, 3'b001, 32'h0000_0001, 32'h0);
        check("lh_mis_err", {31'b0, last_err}, 1);
        check("lh_mis_lat", last_lat, 1);
        run_req(1'b0, 3'b010, 32'h0000_007E, 32'h0);
        check("lw_mis_err", {31'b0, last_err}, 1);
`endif
        run_req(1'b0, 3'b011, 32'h0000_0010, 32'h0);
        check("f3_011_err", {31'b0, last_err}, 1);
        check("f3_011_lat", last_lat, 1);

        // reset during RD0 of a byte store must not write memory
        @(negedge clk);
        #1;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h0000_000E;
        req_wdata  = 32'h0000_005A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rd0_read", {31'b0, mem_read}, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_ready", {31'b0, req_ready}, 1);
        check("rst_mid_read", {31'b0, mem_read}, 0);
        check("rst_mid_write", {31'b0, mem_write}, 0);
        repeat (2) begin
            @(negedge clk);
            check("rst_no_write", {31'b0, mem_write}, 0);
        end
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_write", {31'b0, mem_write}, 0);
        end
        mism = 0;
        for (int i = 0; i < NW; i++)
            if (mem[i] !== ref_mem[i]) mism++;
        check("rst_mem_image", mism, 0);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                if (f3[1:0] == 2'd1) a[0] = 1'b0;
                else if (f3[1:0] != 2'd0) a[1:0] = 2'b00;
            end
            run_req(wr, f3, a, $urandom);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
